block_mult_sequencer: RTL

//  Sequences one 2x2-block matrix multiply C = A*B by driving the select lines of the
//  A-operand and B-operand 16-bit 4:1 block muxes, one (A_ik, B_kj) pair per cycle.
//  It also issues delay-matched accumulate-clear, accumulate-enable and C-write strobes
//  to the multiply-accumulate datapath. A block index is {row,col}, so mux select 2'b01 = block (0,1).

---
 rtl/block_mult_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/block_mult_sequencer.sv
// block_mult_sequencer
//   Sequences one 2x2-block matrix multiply C = A*B. Each ISSUE cycle selects one
//   (A_ik, B_kj) operand pair on the block muxes. A matching {valid,k,i,j} tag
//   travels down a MULT_LATENCY-deep delay line, so the accumulate strobes line up
//   with the product arriving at the accumulator.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; muxes forced to zero
//   ISSUE | issuing operand pairs idx 0..7 = {i,j,k}; stall holds idx
//   DRAIN | MULT_LATENCY cycles letting the last products reach the accumulator
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   start, stall            run request (IDLE only), issue hold (ISSUE only)
//   busy, done              ISSUE/DRAIN indicator, end-of-run pulse
//   sel_a, sel_b            A mux select {i,k}, B mux select {k,j}
//   mux_zero, issue_valid   mux zero-force, live operand pair this cycle
//   acc_clear, acc_en, c_wr delayed accumulate-load, accumulate, C write strobes
//   c_sel                   delayed C block index {i,j}; holds when no strobe
module block_mult_sequencer #(
    parameter int MULT_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b,
    output logic       mux_zero,
    output logic       issue_valid,
    output logic       acc_clear,
    output logic       acc_en,
    output logic       c_wr,
    output logic [1:0] c_sel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       k;
        logic [1:0] ij;
    } tag_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] drain_q, drain_d;
    logic [1:0] c_sel_hold_q, c_sel_hold_d;
    tag_t       dl_q [MULT_LATENCY];
    tag_t       dl_d [MULT_LATENCY];
    tag_t       dl_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            drain_q      <= 4'd0;
            c_sel_hold_q <= 2'd0;
            for (int s = 0; s < MULT_LATENCY; s++) begin
                dl_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drain_q      <= drain_d;
            c_sel_hold_q <= c_sel_hold_d;
            for (int s = 0; s < MULT_LATENCY; s++) begin
                dl_q[s] <= dl_d[s];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        busy        = 1'b0;
        done        = 1'b0;
        sel_a       = 2'd0;
        sel_b       = 2'd0;
        mux_zero    = 1'b1;
        issue_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    idx_d   = 3'd0;
                end
            end
            ISSUE: begin
                busy  = 1'b1;
                // idx = {i,j,k}; selects stay on the held idx during a stall
                sel_a = {idx_q[2], idx_q[0]};
                sel_b = {idx_q[0], idx_q[1]};
                if (!stall) begin
                    issue_valid = 1'b1;
                    mux_zero    = 1'b0;
                    idx_d       = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = DRAIN;
                        // down-counter reaches zero in the final DRAIN cycle
                        drain_d = 4'(MULT_LATENCY - 1);
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Delay line shifts every cycle; a stall enters as an invalid bubble.
    always_comb begin
        dl_d[0].valid = issue_valid;
        dl_d[0].k     = idx_q[0];
        dl_d[0].ij    = idx_q[2:1];
        for (int s = 1; s < MULT_LATENCY; s++) begin
            dl_d[s] = dl_q[s-1];
        end
    end

    assign dl_out = dl_q[MULT_LATENCY-1];

    always_comb begin
        acc_en       = dl_out.valid;
        acc_clear    = dl_out.valid & ~dl_out.k;
        c_wr         = dl_out.valid & dl_out.k;
        // c_sel only moves when a strobe is presented
        c_sel        = dl_out.valid ? dl_out.ij : c_sel_hold_q;
        c_sel_hold_d = c_sel;
    end

endmodule
